// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_ctrl_pkg: shared state encoding and build defaults for the counter sequencer.
package counter_seq_ctrl_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_LIMIT = 15;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;
endpackage

// File: rtl/counter_seq_core.sv
// counter_seq_core: WIDTH-bit load/step register with terminal-value compare.
module counter_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_down,
    input  logic [WIDTH-1:0] i_term_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_term
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_count <= '0;
        else if (i_load) r_count <= i_load_val;
        else if (i_en)   r_count <= i_down ? r_count - 1'b1 : r_count + 1'b1;
    end
    assign o_count = r_count;
    assign o_term  = (r_count == i_term_val);
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/pause/done sequencer, limit latch, pulses and true/complement mux.
// Define COUNTER_SEQ_DOWN_EN to add the dir input and down-counting.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(DEF_LIMIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_inv,
`ifdef COUNTER_SEQ_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_lim, w_count, w_load_val, w_entry_val;
    logic             r_done, r_wrap, w_done_nxt, w_wrap_nxt;
    logic             w_load, w_en, w_lim_ld, w_term, w_dir_in, w_dir_q;

`ifdef COUNTER_SEQ_DOWN_EN
    logic r_dir;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_dir <= 1'b0;
        else if (w_lim_ld) r_dir <= dir;
    end
    assign w_dir_in = dir;
    assign w_dir_q  = r_dir;
`else
    assign w_dir_in = 1'b0;
    assign w_dir_q  = 1'b0;
`endif

    // Fresh runs seed from the incoming limit/direction; resumes keep the held count.
    assign w_entry_val = w_dir_in ? limit : '0;

    counter_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .i_down     (w_dir_q),
        .i_term_val (w_dir_q ? '0 : r_lim),
        .o_count    (w_count),
        .o_term     (w_term)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_en        = 1'b0;
        w_lim_ld    = 1'b0;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: if (start && !stop) begin
                w_state_nxt = ST_RUN;
                w_load      = 1'b1;
                w_load_val  = w_entry_val;
                w_lim_ld    = 1'b1;
            end
            ST_RUN: if (stop) begin
                w_state_nxt = ST_PAUSE;
            end else if (w_term && oneshot) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end else if (w_term) begin
                w_load      = 1'b1;
                w_load_val  = w_dir_q ? r_lim : '0;
                w_wrap_nxt  = 1'b1;
            end else begin
                w_en        = 1'b1;
            end
            ST_PAUSE: if (stop) begin
                w_state_nxt = ST_IDLE;
                w_load      = 1'b1;
            end else if (start) begin
                w_state_nxt = ST_RUN;
            end
            default: if (stop) begin
                w_state_nxt = ST_IDLE;
                w_load      = 1'b1;
            end else if (start) begin
                w_state_nxt = ST_RUN;
                w_load      = 1'b1;
                w_load_val  = w_entry_val;
                w_lim_ld    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_lim   <= DEFAULT_LIMIT;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            if (w_lim_ld) r_lim <= limit;
        end
    end

    assign count = w_count;
    assign res   = out_inv ? ~w_count : w_count;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done  = r_done;
    assign wrap  = r_wrap;
    assign state = r_state;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed and random stimulus against a behavioural sequencer model.
module tb_counter_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, stop, oneshot, out_inv;
    logic [3:0] limit, count, res;
    logic       busy, done, wrap;
    logic [1:0] state;
    int checks = 0;
    int failures = 0;
    int m_st, m_cnt, m_lim, m_done, m_wrap;

    always #5 clk = ~clk;

    counter_seq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .limit   (limit),
        .out_inv (out_inv),
        .count   (count),
        .res     (res),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap),
        .state   (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_lim = 15; m_done = 0; m_wrap = 0;
    endtask

    // Phases: 0 idle, 1 run, 2 pause, 3 done; one call per rising edge.
    task automatic model_edge();
        m_done = 0;
        m_wrap = 0;
        if (m_st == 0) begin
            if (start && !stop) begin m_st = 1; m_cnt = 0; m_lim = int'(limit); end
        end else if (m_st == 1) begin
            if (stop) m_st = 2;
            else if (m_cnt == m_lim && oneshot) begin m_st = 3; m_done = 1; end
            else if (m_cnt == m_lim) begin m_cnt = 0; m_wrap = 1; end
            else m_cnt = (m_cnt + 1) % 16;
        end else if (m_st == 2) begin
            if (stop) begin m_st = 0; m_cnt = 0; end
            else if (start) m_st = 1;
        end else begin
            if (stop) begin m_st = 0; m_cnt = 0; end
            else if (start) begin m_st = 1; m_cnt = 0; m_lim = int'(limit); end
        end
    endtask

    task automatic check_all();
        logic [3:0] c;
        c = m_cnt[3:0];
        chk("count", {4'h0, count}, {4'h0, c});
        chk("res",   {4'h0, res},   {4'h0, out_inv ? ~c : c});
        chk("busy",  {7'h0, busy},  {7'h0, m_st == 1 || m_st == 2});
        chk("done",  {7'h0, done},  8'(m_done));
        chk("wrap",  {7'h0, wrap},  8'(m_wrap));
        chk("state", {6'h0, state}, 8'(m_st));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; out_inv = 1'b0; limit = 4'h0;
        model_reset();
        #12 check_all();
        @(negedge clk) reset = 1'b1;
        step(1);
        oneshot = 1'b1; limit = 4'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("os_cnt3", {4'h0, count}, 8'd3);
        step(1);
        chk("os_done", {7'h0, done}, 8'd1);
        chk("os_state", {6'h0, state}, 8'd3);
        step(1);
        chk("os_done_clr", {7'h0, done}, 8'd0);
        chk("os_hold", {4'h0, count}, 8'd3);
        stop = 1'b1;
        step(1);
        stop = 1'b0; oneshot = 1'b0; limit = 4'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("fr_cnt2", {4'h0, count}, 8'd2);
        step(1);
        chk("fr_wrap", {7'h0, wrap}, 8'd1);
        chk("fr_zero", {4'h0, count}, 8'd0);
        step(3);
        stop = 1'b1;
        step(2);
        stop = 1'b0; limit = 4'd9; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(2);
        chk("pause_hold", {4'h0, count}, 8'd4);
        chk("pause_state", {6'h0, state}, 8'd2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("resume5", {4'h0, count}, 8'd5);
        stop = 1'b1;
        step(2);
        chk("stop_idle", {6'h0, state}, 8'd0);
        start = 1'b1;
        step(2);
        chk("both_idle", {6'h0, state}, 8'd0);
        stop = 1'b0; oneshot = 1'b1; limit = 4'd0;
        step(1);
        start = 1'b0;
        step(1);
        chk("lim0_done", {6'h0, state}, 8'd3);
        oneshot = 1'b0; limit = 4'd9; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        out_inv = 1'b1;
        #1 chk("res_inv", {4'h0, res}, 8'h0C);
        out_inv = 1'b0;
        #1 chk("res_true", {4'h0, res}, 8'h03);
        step(2);
        #2 reset = 1'b0;
        #1 chk("arst_cnt", {4'h0, count}, 8'd0);
        chk("arst_state", {6'h0, state}, 8'd0);
        chk("arst_busy", {7'h0, busy}, 8'd0);
        chk("arst_done", {7'h0, done}, 8'd0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        check_all();
        repeat (500) begin
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 7) == 0);
            oneshot = 1'($urandom);
            limit   = 4'($urandom);
            out_inv = 1'($urandom);
            step(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
